// File: rtl/missile_ctrl.sv
// missile_ctrl: round-robin missile slot manager driven by frame ticks.
// Ports: vga_clk_i clock; vga_rst_i synchronous active-low reset;
//   frame_tick_i per-frame pulse; fire_i fire button level; player_col_i launch column;
//   hit_i per-slot hit pulse; missle_en_o slot-in-flight flags;
//   missle_col_o / missle_row_o packed slot positions (slot 0 in the LSBs);
//   fire_ack_o launch acknowledge pulse; full_o all slots in flight.
// Optional: define MISSILE_HIT_CLEAR_EN to let hit_i retire a flying slot.
module missile_ctrl #(
  parameter int NUM_SLOTS       = 3,
  parameter int COL_W           = 12,
  parameter int Y_START         = 420,
  parameter int Y_TOP           = 16,
  parameter int STEP            = 4,
  parameter int COOLDOWN_FRAMES = 2
) (
  input  logic                       vga_clk_i,
  input  logic                       vga_rst_i,
  input  logic                       frame_tick_i,
  input  logic                       fire_i,
  input  logic [COL_W-1:0]           player_col_i,
  input  logic [NUM_SLOTS-1:0]       hit_i,
  output logic [NUM_SLOTS-1:0]       missle_en_o,
  output logic [NUM_SLOTS*COL_W-1:0] missle_col_o,
  output logic [NUM_SLOTS*COL_W-1:0] missle_row_o,
  output logic                       fire_ack_o,
  output logic                       full_o
);
  localparam int PW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(COOLDOWN_FRAMES + 2);
  typedef enum logic {IDLE, FLYING} state_e;
  state_e           st_q  [NUM_SLOTS];
  state_e           st_d  [NUM_SLOTS];
  logic [COL_W-1:0] row_q [NUM_SLOTS];
  logic [COL_W-1:0] row_d [NUM_SLOTS];
  logic [COL_W-1:0] col_q [NUM_SLOTS];
  logic [COL_W-1:0] col_d [NUM_SLOTS];
  logic [PW-1:0]    rr_q, sel;
  logic [CW-1:0]    cd_q;
  logic             fire_q, pend_q, found, launch;
  logic [NUM_SLOTS-1:0] hit_m, en_d;
  int               j;
`ifdef MISSILE_HIT_CLEAR_EN
  assign hit_m = hit_i;
`else
  logic unused_hit;
  assign unused_hit = ^hit_i;
  assign hit_m = '0;
`endif
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
    assign missle_en_o[g]                  = st_q[g] == FLYING;
    assign missle_row_o[g*COL_W +: COL_W] = row_q[g];
    assign missle_col_o[g*COL_W +: COL_W] = col_q[g];
  end
  // Scan downward so the idle slot closest after rr_q is the last one written.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      j = int'(rr_q) + i;
      j = j >= NUM_SLOTS ? j - NUM_SLOTS : j;
      if (st_q[PW'(j)] == IDLE) begin
        sel   = PW'(j);
        found = 1'b1;
      end
    end
  end
  // Launch uses pre-tick idle status, so a slot retiring this tick is not reused.
  always_comb begin
    launch = frame_tick_i & pend_q & (cd_q == '0) & found;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      st_d[k]  = st_q[k];
      row_d[k] = row_q[k];
      col_d[k] = col_q[k];
      if (launch && sel == PW'(k)) begin
        st_d[k]  = FLYING;
        row_d[k] = COL_W'(Y_START);
        col_d[k] = player_col_i;
      end else if (st_q[k] == FLYING && hit_m[k]) begin
        st_d[k] = IDLE;
      end else if (st_q[k] == FLYING && frame_tick_i) begin
        // Compare against Y_TOP+STEP before subtracting so the row never wraps.
        st_d[k]  = row_q[k] < COL_W'(Y_TOP + STEP) ? IDLE : FLYING;
        row_d[k] = row_q[k] < COL_W'(Y_TOP + STEP) ? row_q[k] : row_q[k] - COL_W'(STEP);
      end
      en_d[k] = st_d[k] == FLYING;
    end
  end
  always_ff @(posedge vga_clk_i) begin
    if (!vga_rst_i) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        st_q[k]  <= IDLE;
        row_q[k] <= COL_W'(Y_START);
        col_q[k] <= '0;
      end
      rr_q       <= '0;
      cd_q       <= '0;
      pend_q     <= 1'b0;
      fire_q     <= 1'b0;
      fire_ack_o <= 1'b0;
      full_o     <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        st_q[k]  <= st_d[k];
        row_q[k] <= row_d[k];
        col_q[k] <= col_d[k];
      end
      fire_q     <= fire_i;
      pend_q     <= launch ? 1'b0 : pend_q | (fire_i & ~fire_q);
      rr_q       <= launch ? (sel == PW'(NUM_SLOTS - 1) ? '0 : sel + PW'(1)) : rr_q;
      cd_q       <= launch ? CW'(COOLDOWN_FRAMES) : (frame_tick_i && cd_q != '0) ? cd_q - CW'(1) : cd_q;
      fire_ack_o <= launch;
      full_o     <= &en_d;
    end
  end
endmodule

// File: tb/tb_missile_ctrl.sv
// tb_missile_ctrl: randomized and directed checks of missile_ctrl against a slot-level model.
module tb_missile_ctrl;
  localparam int N = 3;
  localparam int W = 12;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, fire = 1'b0;
  logic [W-1:0] pcol = '0;
  logic [N-1:0] hit = '0;
  logic [N-1:0] en;
  logic [N*W-1:0] cols, rows;
  logic ack, full;
  int tests = 0, fails = 0;
  int m_fly[N], m_row[N], m_col[N];
  int m_rr = 0, m_cd = 0, m_pend = 0, m_fire = 0, m_ack = 0, m_full = 0;
  always #5 clk = ~clk;
  missile_ctrl dut (
    .vga_clk_i(clk), .vga_rst_i(rst_n), .frame_tick_i(tick), .fire_i(fire),
    .player_col_i(pcol), .hit_i(hit), .missle_en_o(en), .missle_col_o(cols),
    .missle_row_o(rows), .fire_ack_o(ack), .full_o(full)
  );
  function automatic int rw(int k);
    return int'(rows[k*W +: W]);
  endfunction
  function automatic int cl(int k);
    return int'(cols[k*W +: W]);
  endfunction
  // Behavioural model: one call per clock, using the inputs applied for that cycle.
  function automatic void model_step();
    int s;
    int ls = -1;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_fly[k] = 0; m_row[k] = 420; m_col[k] = 0;
      end
      m_rr = 0; m_cd = 0; m_pend = 0; m_fire = 0; m_ack = 0; m_full = 0;
      return;
    end
    if (tick && m_pend != 0 && m_cd == 0)
      for (int i = 0; i < N; i++) begin
        s = (m_rr + i) % N;
        if (m_fly[s] == 0 && ls < 0) ls = s;
      end
    for (int k = 0; k < N; k++)
      if (m_fly[k] != 0) begin
`ifdef MISSILE_HIT_CLEAR_EN
        if (hit[k]) m_fly[k] = 0;
        else
`endif
        if (tick) begin
          if (m_row[k] - 4 < 16) m_fly[k] = 0;
          else m_row[k] -= 4;
        end
      end
    if (ls >= 0) begin
      m_fly[ls] = 1; m_row[ls] = 420; m_col[ls] = int'(pcol);
      m_rr = (ls + 1) % N; m_cd = 2; m_pend = 0;
    end else begin
      if (tick && m_cd > 0) m_cd--;
      if (fire && m_fire == 0) m_pend = 1;
    end
    m_fire = int'(fire);
    m_ack = ls >= 0 ? 1 : 0;
    m_full = (m_fly[0] != 0 && m_fly[1] != 0 && m_fly[2] != 0) ? 1 : 0;
  endfunction
  task automatic cyc(input logic r, input logic t, input logic f, input logic [W-1:0] c, input logic [N-1:0] h);
    rst_n = r; tick = t; fire = f; pcol = c; hit = h;
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 12'd77, 3'b111);
    tests++; if (en !== 3'b000) begin fails++; $display("FAIL reset_en got %b want 000", en); end
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", ack); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", full); end
    for (int k = 0; k < N; k++) begin
      tests++; if (rw(k) != 420 || cl(k) != 0) begin fails++; $display("FAIL reset_slot%0d got row %0d col %0d want 420 0", k, rw(k), cl(k)); end
    end
  endtask
  task automatic test_first_launch();
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 1, 12'd200, 0);
    tests++; if (ack !== 1'b0 || en !== 3'b000) begin fails++; $display("FAIL launch_without_tick got ack %b en %b want 0 000", ack, en); end
    cyc(1, 1, 1, 12'd200, 0);
    tests++; if (en !== 3'b001) begin fails++; $display("FAIL launch_en got %b want 001", en); end
    tests++; if (rw(0) != 420 || cl(0) != 200) begin fails++; $display("FAIL launch_pos got row %0d col %0d want 420 200", rw(0), cl(0)); end
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL launch_ack got %b want 1", ack); end
    cyc(1, 0, 0, 0, 0);
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL ack_one_cycle got %b want 0", ack); end
  endtask
  task automatic test_retire();
    for (int i = 0; i < 101; i++) cyc(1, 1, 0, 0, 0);
    tests++; if (rw(0) != 16 || en[0] !== 1'b1) begin fails++; $display("FAIL retire_top got row %0d en %b want 16 1", rw(0), en[0]); end
    cyc(1, 1, 0, 0, 0);
    tests++; if (en[0] !== 1'b0 || rw(0) != 16) begin fails++; $display("FAIL retire_done got en %b row %0d want 0 16", en[0], rw(0)); end
  endtask
  task automatic test_cooldown();
    int bad = 0;
    cyc(0, 0, 0, 0, 0);
    for (int t = 1; t <= 104; t++) begin
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 1, W'(t), 0);
      cyc(1, 1, 1, W'(t), 0);
      if (t == 1 || t == 4 || t == 7 || t == 104) begin
        tests++; if (ack !== 1'b1) begin fails++; $display("FAIL cooldown_ack_t%0d got %b want 1", t, ack); end
      end else if (ack !== 1'b0) bad++;
      if (t == 1) begin tests++; if (en !== 3'b001) begin fails++; $display("FAIL cooldown_en_t1 got %b want 001", en); end end
      if (t == 4) begin tests++; if (en !== 3'b011 || cl(1) != 4) begin fails++; $display("FAIL cooldown_t4 got en %b col1 %0d want 011 4", en, cl(1)); end end
      if (t == 7) begin tests++; if (en !== 3'b111 || full !== 1'b1) begin fails++; $display("FAIL cooldown_t7 got en %b full %b want 111 1", en, full); end end
      if (t == 103) begin tests++; if (en !== 3'b110 || full !== 1'b0) begin fails++; $display("FAIL held_t103 got en %b full %b want 110 0", en, full); end end
      if (t == 104) begin tests++; if (en !== 3'b111 || rw(0) != 420 || cl(0) != 104) begin fails++; $display("FAIL relaunch got en %b row0 %0d col0 %0d want 111 420 104", en, rw(0), cl(0)); end end
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL early_acks got %0d want 0", bad); end
  endtask
  task automatic test_hit();
    int r0 = rw(0), r1 = rw(1), r2 = rw(2);
    cyc(1, 1, 0, 0, 3'b010);
`ifdef MISSILE_HIT_CLEAR_EN
    tests++; if (en !== 3'b101 || rw(1) != r1) begin fails++; $display("FAIL hit_clear got en %b row1 %0d want 101 %0d", en, rw(1), r1); end
`else
    tests++; if (en !== 3'b111 || rw(1) != r1 - 4) begin fails++; $display("FAIL hit_ignored_tick got en %b row1 %0d want 111 %0d", en, rw(1), r1 - 4); end
`endif
    tests++; if (rw(0) != r0 - 4 || rw(2) != r2 - 4) begin fails++; $display("FAIL hit_others got %0d %0d want %0d %0d", rw(0), rw(2), r0 - 4, r2 - 4); end
`ifndef MISSILE_HIT_CLEAR_EN
    cyc(1, 0, 0, 0, 3'b111);
    tests++; if (en !== 3'b111) begin fails++; $display("FAIL hit_ignored got en %b want 111", en); end
`endif
  endtask
  task automatic test_reset_midflight();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 12'd9, 0);
    cyc(0, 1, 1, 12'd9, 3'b111);
    tests++; if (en !== 3'b000 || ack !== 1'b0) begin fails++; $display("FAIL midreset got en %b ack %b want 000 0", en, ack); end
    tests++; if (rw(0) != 420 || rw(1) != 420 || rw(2) != 420) begin fails++; $display("FAIL midreset_rows got %0d %0d %0d want 420", rw(0), rw(1), rw(2)); end
    cyc(1, 1, 1, 12'd9, 0);
    tests++; if (ack !== 1'b0 || en !== 3'b000) begin fails++; $display("FAIL pending_cleared got ack %b en %b want 0 000", ack, en); end
  endtask
  task automatic test_random();
    logic [N-1:0] ee;
    logic [N*W-1:0] er, ec;
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 200) != 0, ($urandom % 3) == 0, $urandom % 2 == 1, W'($urandom), N'($urandom));
      for (int k = 0; k < N; k++) begin
        ee[k] = m_fly[k] != 0; er[k*W +: W] = W'(m_row[k]); ec[k*W +: W] = W'(m_col[k]);
      end
      tests++; if (en !== ee) begin fails++; $display("FAIL rand_en cyc %0d got %b want %b", i, en, ee); end
      tests++; if (rows !== er) begin fails++; $display("FAIL rand_rows cyc %0d got %h want %h", i, rows, er); end
      tests++; if (cols !== ec) begin fails++; $display("FAIL rand_cols cyc %0d got %h want %h", i, cols, ec); end
      tests++; if (ack !== m_ack[0]) begin fails++; $display("FAIL rand_ack cyc %0d got %b want %0d", i, ack, m_ack); end
      tests++; if (full !== m_full[0]) begin fails++; $display("FAIL rand_full cyc %0d got %b want %0d", i, full, m_full); end
    end
  endtask
  initial begin
    test_reset();
    test_first_launch();
    test_retire();
    test_cooldown();
    test_hit();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
